// File: rtl/soc_io_pkg.sv
// Shared definitions for the SoC I/O port: register map, STATUS bit layout and bus FSM states.
package soc_io_pkg;

  localparam int unsigned OFF_OPR1   = 0;
  localparam int unsigned OFF_OPR2   = 1;
  localparam int unsigned OFF_RESULT = 2;
  localparam int unsigned OFF_STATUS = 3;

  localparam int unsigned STAT_OPR_CHANGED   = 0;
  localparam int unsigned STAT_RESULT_WRITTEN = 1;
  localparam int unsigned STAT_W              = 2;

  typedef enum logic {
    IDLE,
    ACK
  } bus_state_e;

endpackage

// File: rtl/io_sync_reg.sv
// Multi-flop synchroniser feeding an operand register; flags when the register takes a new value.
module io_sync_reg #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             changed_o
);

  logic [Stages-1:0][Width-1:0] sync_q;
  logic [Width-1:0]             q_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      q_q    <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      q_q <= sync_q[Stages-1];
    end
  end

  assign q_o       = q_q;
  // High on the cycle whose edge loads a different value into the operand register.
  assign changed_o = (sync_q[Stages-1] != q_q);

endmodule

// File: rtl/soc_io_port.sv
// Memory-mapped responder linking the CPU load/store bus to the external operand and result pins.
module soc_io_port
  import soc_io_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              base_clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  input  logic [7:0]        opr1,
  input  logic [7:0]        opr2,
  output logic [15:0]       result,
  output logic              result_strobe
);

  localparam int unsigned IdxW = ADDR_W - 2;

  bus_state_e          state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         result_q, result_d;
  logic                strobe_q, strobe_d;
  logic [STAT_W-1:0]   status_q, status_d;

  logic [7:0]          opr1_q, opr2_q;
  logic                opr1_chg, opr2_chg;
  logic [IdxW-1:0]     idx;
  logic                accept;

  io_sync_reg #(.Width(8), .Stages(SYNC_STAGES)) u_sync_opr1 (
    .clk_i     (base_clk),
    .reset_i   (reset),
    .d_i       (opr1),
    .q_o       (opr1_q),
    .changed_o (opr1_chg)
  );

  io_sync_reg #(.Width(8), .Stages(SYNC_STAGES)) u_sync_opr2 (
    .clk_i     (base_clk),
    .reset_i   (reset),
    .d_i       (opr2),
    .q_o       (opr2_q),
    .changed_o (opr2_chg)
  );

  assign idx    = bus_addr[ADDR_W-1:2];
  assign accept = (state_q == IDLE) && bus_req;

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    result_d = result_q;
    strobe_d = 1'b0;
    status_d = status_q;

    unique case (state_q)
      IDLE: begin
        if (bus_req) begin
          state_d = ACK;
          rdata_d = '0;
          if (idx == IdxW'(OFF_OPR1)) begin
            if (!bus_we) rdata_d = DATA_W'(opr1_q);
          end else if (idx == IdxW'(OFF_OPR2)) begin
            if (!bus_we) rdata_d = DATA_W'(opr2_q);
          end else if (idx == IdxW'(OFF_RESULT)) begin
            if (bus_we) begin
              result_d = bus_wdata[15:0];
              strobe_d = 1'b1;
              status_d[STAT_RESULT_WRITTEN] = 1'b1;
            end else begin
              rdata_d = DATA_W'(result_q);
            end
          end else if (idx == IdxW'(OFF_STATUS)) begin
            if (bus_we) status_d = status_q & ~bus_wdata[STAT_W-1:0];
            else        rdata_d  = DATA_W'(status_q);
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Set events are applied after any W1C clear so a coincident set wins.
    if (opr1_chg || opr2_chg) status_d[STAT_OPR_CHANGED] = 1'b1;
    if (accept && bus_we && (idx == IdxW'(OFF_RESULT))) status_d[STAT_RESULT_WRITTEN] = 1'b1;
  end

  always_ff @(posedge base_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      result_q <= '0;
      strobe_q <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      result_q <= result_d;
      strobe_q <= strobe_d;
      status_q <= status_d;
    end
  end

  assign bus_ack       = (state_q == ACK);
  assign bus_rdata     = bus_ack ? rdata_q : '0;
  assign result        = result_q;
  assign result_strobe = strobe_q;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[DATA_W-1:16]};

endmodule
